// File: rtl/delay_pkg.sv
// Shared definitions for the delay strobe generator and its period monitor.
// Both sides import these defaults so they agree on the terminal count and
// the gap counter width without repeating literals.
package delay_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    localparam int DEF_N     = 1250;
    localparam int DEF_CBITS = 11;

    // The generator counts 0..n, so one strobe appears every n+1 cycles.
    function automatic int calcPeriod(input int n);
        return n + 1;
    endfunction

    // Shortest accepted period.
    function automatic int calcLower(input int n, input int tol);
        return n + 1 - tol;
    endfunction

    // Longest accepted period.
    function automatic int calcUpper(input int n, input int tol);
        return n + 1 + tol;
    endfunction

endpackage

// File: rtl/delay_tick_monitor_if.sv
// Strobe input and status outputs of the tick monitor, bundled together.
// The monitor is the slave; whoever drives the strobe and reads the
// status is the master.
interface delay_tick_monitor_if #(
    parameter int CBITS = 11,
    parameter int MBITS = 8
);
    logic             sig;
    logic [CBITS-1:0] gap;
    logic             locked;
    logic             early;
    logic             late;
    logic             err;
    logic [MBITS-1:0] miss_cnt;

    modport master (
        output sig,
        input  gap, locked, early, late, err, miss_cnt
    );

    modport slave (
        input  sig,
        output gap, locked, early, late, err, miss_cnt
    );
endinterface

// File: rtl/delay_gap_counter.sv
// Saturating count of cycles since the last accepted strobe, plus the three
// window comparisons the monitor FSM needs. The comparisons are done on the
// raw gap against pre-decremented bounds, so measured = gap+1 never has to
// be formed and cannot overflow the counter width.
module delay_gap_counter
    import delay_pkg::*;
#(
    parameter int CBITS = DEF_CBITS,
    parameter int LO    = calcLower(DEF_N, 0),
    parameter int HI    = calcUpper(DEF_N, 0)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CBITS-1:0] o_gap,
    output logic             o_inWindow,
    output logic             o_tooEarly,
    output logic             o_timeout
);

    localparam logic [CBITS-1:0] LO_M1   = CBITS'(LO - 1);
    localparam logic [CBITS-1:0] HI_M1   = CBITS'(HI - 1);
    localparam logic [CBITS-1:0] HI_GAP  = CBITS'(HI);
    localparam logic [CBITS-1:0] GAP_ONE = CBITS'(1);
    localparam logic [CBITS-1:0] GAP_MAX = '1;

    logic [CBITS-1:0] r_gap;

    // Clear wins over counting; counting stops at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap <= '0;
        end else if (i_clear) begin
            r_gap <= '0;
        end else if (i_enable && (r_gap != GAP_MAX)) begin
            r_gap <= r_gap + GAP_ONE;
        end
    end

    assign o_gap      = r_gap;
    assign o_tooEarly = (r_gap < LO_M1);
    assign o_inWindow = (r_gap >= LO_M1) && (r_gap <= HI_M1);
    assign o_timeout  = (r_gap == HI_GAP);

endmodule

// File: rtl/delay_tick_monitor.sv
// Period checker for the delay counter strobe. Takes the first strobe as a
// phase reference, then grades each following strobe against the expected
// period, declares lock after a run of good periods and keeps sticky error
// and saturating miss statistics.
module delay_tick_monitor
    import delay_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int CBITS    = DEF_CBITS,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int MBITS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    delay_tick_monitor_if.slave bus
);

    localparam int P      = calcPeriod(N);
    localparam int LO     = calcLower(N, TOL);
    localparam int HI     = calcUpper(N, TOL);
    localparam int GRBITS = $clog2(LOCK_CNT + 1);

    localparam logic [GRBITS-1:0] GR_ONE   = GRBITS'(1);
    localparam logic [GRBITS-1:0] GR_LOCK  = GRBITS'(LOCK_CNT);
    localparam logic [MBITS-1:0]  MISS_ONE = MBITS'(1);
    localparam logic [MBITS-1:0]  MISS_MAX = '1;

    // The counter must reach the timeout value and still have headroom.
    if ((N + TOL + 2) > (2 ** CBITS - 1)) begin : g_badCbits
        $error("delay_tick_monitor: CBITS too small for N+TOL");
    end
    if (TOL >= P) begin : g_badTol
        $error("delay_tick_monitor: TOL must be smaller than the period");
    end
    if (LOCK_CNT < 1) begin : g_badLock
        $error("delay_tick_monitor: LOCK_CNT must be at least 1");
    end

    mon_state_t        r_state;
    mon_state_t        w_nextState;
    logic [GRBITS-1:0] r_goodRun;
    logic [GRBITS-1:0] w_nextGoodRun;
    logic              w_earlyEv;
    logic              w_lateEv;

    logic              r_locked;
    logic              r_early;
    logic              r_late;
    logic              r_err;
    logic [MBITS-1:0]  r_missCnt;

    logic [CBITS-1:0]  w_gap;
    logic              w_inWindow;
    logic              w_tooEarly;
    logic              w_timeout;
    logic              w_gapClear;
    logic              w_gapEnable;

    // Gap is pinned at 0 until a reference exists and restarts on every
    // strobe or on a timeout.
    assign w_gapClear  = (r_state == SYNC) || bus.sig || w_timeout;
    assign w_gapEnable = (r_state != SYNC);

    delay_gap_counter #(
        .CBITS (CBITS),
        .LO    (LO),
        .HI    (HI)
    ) u_gapCounter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_gapClear),
        .i_enable   (w_gapEnable),
        .o_gap      (w_gap),
        .o_inWindow (w_inWindow),
        .o_tooEarly (w_tooEarly),
        .o_timeout  (w_timeout)
    );

    // Next-state logic: timeout takes precedence over any strobe in the same
    // cycle, so a strobe arriving exactly one cycle too late counts as late
    // but still serves as the new phase reference.
    always_comb begin
        w_nextState   = r_state;
        w_nextGoodRun = r_goodRun;
        w_earlyEv     = 1'b0;
        w_lateEv      = 1'b0;
        unique case (r_state)
            SYNC: begin
                if (bus.sig) begin
                    w_nextState   = HUNT;
                    w_nextGoodRun = '0;
                end
            end
            HUNT, LOCKED: begin
                if (w_timeout) begin
                    w_lateEv      = 1'b1;
                    w_nextGoodRun = '0;
                    w_nextState   = bus.sig ? HUNT : SYNC;
                end else if (bus.sig) begin
                    if (w_inWindow) begin
                        if (r_state == HUNT) begin
                            w_nextGoodRun = r_goodRun + GR_ONE;
                            if ((r_goodRun + GR_ONE) == GR_LOCK) begin
                                w_nextState = LOCKED;
                            end
                        end
                    end else if (w_tooEarly) begin
                        w_earlyEv     = 1'b1;
                        w_nextGoodRun = '0;
                        w_nextState   = HUNT;
                    end
                end
            end
            default: begin
                w_nextState   = SYNC;
                w_nextGoodRun = '0;
            end
        endcase
    end

    // State and good-period run register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= SYNC;
            r_goodRun <= '0;
        end else begin
            r_state   <= w_nextState;
            r_goodRun <= w_nextGoodRun;
        end
    end

    // Registered status: one-cycle event pulses, lock flag and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked  <= 1'b0;
            r_early   <= 1'b0;
            r_late    <= 1'b0;
            r_err     <= 1'b0;
            r_missCnt <= '0;
        end else begin
            r_locked <= (w_nextState == LOCKED);
            r_early  <= w_earlyEv;
            r_late   <= w_lateEv;
            if (w_earlyEv || w_lateEv) begin
                r_err <= 1'b1;
                if (r_missCnt != MISS_MAX) begin
                    r_missCnt <= r_missCnt + MISS_ONE;
                end
            end
        end
    end

    assign bus.gap      = w_gap;
    assign bus.locked   = r_locked;
    assign bus.early    = r_early;
    assign bus.late     = r_late;
    assign bus.err      = r_err;
    assign bus.miss_cnt = r_missCnt;

endmodule

// File: tb/tb_delay_tick_monitor.sv
// Directed bench for delay_tick_monitor. Three instances cover the default
// configuration, a tolerance of one cycle and a tiny period with a 2-bit
// miss counter. A vector table drives strobes at given spacings and lists
// the expected status after each; a hand-written sequence covers reset
// arriving together with a strobe while locked.
module tb_delay_tick_monitor;

    logic clk = 1'b0;
    logic rstA, rstB, rstC;

    always #5 clk = ~clk;

    delay_tick_monitor_if #(.CBITS(11), .MBITS(8)) ifA ();
    delay_tick_monitor_if #(.CBITS(11), .MBITS(8)) ifB ();
    delay_tick_monitor_if #(.CBITS(4),  .MBITS(2)) ifC ();

    delay_tick_monitor #(.N(1250), .CBITS(11), .TOL(0), .LOCK_CNT(4), .MBITS(8)) dutA (
        .clk (clk), .rst (rstA), .bus (ifA.slave)
    );
    delay_tick_monitor #(.N(1250), .CBITS(11), .TOL(1), .LOCK_CNT(4), .MBITS(8)) dutB (
        .clk (clk), .rst (rstB), .bus (ifB.slave)
    );
    delay_tick_monitor #(.N(3), .CBITS(4), .TOL(0), .LOCK_CNT(4), .MBITS(2)) dutC (
        .clk (clk), .rst (rstC), .bus (ifC.slave)
    );

    typedef struct {
        int dut;
        int waitCycles;
        int pulse;
        int expLocked;
        int expEarly;
        int expLate;
        int expErr;
        int expMiss;
        int expGap;
    } vec_t;

    vec_t vecs[$];
    int   nCompared   = 0;
    int   nMismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setSig(input int dut, input int v);
        case (dut)
            0:       ifA.sig = (v != 0);
            1:       ifB.sig = (v != 0);
            default: ifC.sig = (v != 0);
        endcase
    endtask

    // waitCycles edges in total; only the last one may see the strobe.
    task automatic applyStimulus(input int dut, input int waitCycles, input int pulse);
        setSig(dut, 0);
        for (int i = 0; i < waitCycles - 1; i++) tick();
        setSig(dut, pulse);
        tick();
        setSig(dut, 0);
    endtask

    task automatic compareField(input string nm, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int dut,
                               input int eLocked, input int eEarly, input int eLate,
                               input int eErr, input int eMiss, input int eGap);
        int aLocked, aEarly, aLate, aErr, aMiss, aGap;
        case (dut)
            0: begin
                aLocked = int'(ifA.locked); aEarly = int'(ifA.early); aLate = int'(ifA.late);
                aErr = int'(ifA.err); aMiss = int'(ifA.miss_cnt); aGap = int'(ifA.gap);
            end
            1: begin
                aLocked = int'(ifB.locked); aEarly = int'(ifB.early); aLate = int'(ifB.late);
                aErr = int'(ifB.err); aMiss = int'(ifB.miss_cnt); aGap = int'(ifB.gap);
            end
            default: begin
                aLocked = int'(ifC.locked); aEarly = int'(ifC.early); aLate = int'(ifC.late);
                aErr = int'(ifC.err); aMiss = int'(ifC.miss_cnt); aGap = int'(ifC.gap);
            end
        endcase
        compareField({tag, ".locked"}, aLocked, eLocked);
        compareField({tag, ".early"},  aEarly,  eEarly);
        compareField({tag, ".late"},   aLate,   eLate);
        compareField({tag, ".err"},    aErr,    eErr);
        compareField({tag, ".miss"},   aMiss,   eMiss);
        compareField({tag, ".gap"},    aGap,    eGap);
    endtask

    initial begin
        // dut, wait, pulse, locked, early, late, err, miss, gap
        // A: P=1251, TOL=0
        vecs.push_back('{0,    5, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{0, 1251, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{0, 1251, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{0, 1251, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{0, 1251, 1, 1, 0, 0, 0, 0,    0});
        vecs.push_back('{0,  600, 0, 1, 0, 0, 0, 0,  600});
        vecs.push_back('{0,  651, 1, 1, 0, 0, 0, 0,    0});
        vecs.push_back('{0, 1250, 1, 0, 1, 0, 1, 1,    0});
        vecs.push_back('{0,    1, 0, 0, 0, 0, 1, 1,    1});
        vecs.push_back('{0, 1250, 1, 0, 0, 0, 1, 1,    0});
        vecs.push_back('{0, 1251, 1, 0, 0, 0, 1, 1,    0});
        vecs.push_back('{0, 1251, 1, 0, 0, 0, 1, 1,    0});
        vecs.push_back('{0, 1251, 1, 1, 0, 0, 1, 1,    0});
        vecs.push_back('{0, 1251, 0, 1, 0, 0, 1, 1, 1251});
        vecs.push_back('{0,    1, 0, 0, 0, 1, 1, 2,    0});
        vecs.push_back('{0,    1, 0, 0, 0, 0, 1, 2,    0});
        vecs.push_back('{0, 2000, 0, 0, 0, 0, 1, 2,    0});
        // B: P=1251, TOL=1, window 1250..1252
        vecs.push_back('{1,    3, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{1, 1250, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{1, 1252, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{1, 1251, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{1, 1250, 1, 1, 0, 0, 0, 0,    0});
        vecs.push_back('{1, 1253, 1, 0, 0, 1, 1, 1,    0});
        vecs.push_back('{1, 1251, 1, 0, 0, 0, 1, 1,    0});
        vecs.push_back('{1, 1249, 1, 0, 1, 0, 1, 2,    0});
        // C: P=4, TOL=0, 2-bit miss counter
        vecs.push_back('{2,    2, 1, 0, 0, 0, 0, 0,    0});
        vecs.push_back('{2,    1, 1, 0, 1, 0, 1, 1,    0});
        vecs.push_back('{2,    1, 1, 0, 1, 0, 1, 2,    0});
        vecs.push_back('{2,    2, 1, 0, 1, 0, 1, 3,    0});
        vecs.push_back('{2,    3, 1, 0, 1, 0, 1, 3,    0});
        vecs.push_back('{2,    1, 1, 0, 1, 0, 1, 3,    0});
        vecs.push_back('{2,    4, 0, 0, 0, 0, 1, 3,    4});
        vecs.push_back('{2,    1, 0, 0, 0, 1, 1, 3,    0});

        ifA.sig = 1'b0;
        ifB.sig = 1'b0;
        ifC.sig = 1'b0;
        rstA = 1'b1;
        rstB = 1'b1;
        rstC = 1'b1;
        tick();
        ifA.sig = 1'b1;
        tick();
        tick();
        ifA.sig = 1'b0;
        checkOutput("resetA", 0, 0, 0, 0, 0, 0, 0);
        checkOutput("resetB", 1, 0, 0, 0, 0, 0, 0);
        checkOutput("resetC", 2, 0, 0, 0, 0, 0, 0);
        rstA = 1'b0;
        rstB = 1'b0;
        rstC = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].dut, vecs[k].waitCycles, vecs[k].pulse);
            checkOutput($sformatf("vec%0d", k), vecs[k].dut,
                        vecs[k].expLocked, vecs[k].expEarly, vecs[k].expLate,
                        vecs[k].expErr, vecs[k].expMiss, vecs[k].expGap);
        end

        // Lock A again from SYNC, then reset it on a cycle carrying a strobe.
        applyStimulus(0, 3, 1);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1251, 1);
        checkOutput("relockA", 0, 1, 0, 0, 1, 2, 0);
        for (int k = 0; k < 1250; k++) tick();
        rstA    = 1'b1;
        ifA.sig = 1'b1;
        tick();
        rstA    = 1'b0;
        ifA.sig = 1'b0;
        checkOutput("rstWithSig", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 10, 1);
        checkOutput("afterRstP1", 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1251, 1);
        checkOutput("afterRstP4", 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1251, 1);
        checkOutput("afterRstP5", 0, 1, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
